fp_wb_regfile: RTL



---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_mfc_buf.sv | 53 +++++
 rtl/fp_wb_regfile.sv | 119 +++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared constants for the FP datapath: register-file geometry, the FP zero
// encoding, and the fp_ctl opcode values shared with the FP ALU.
// ---------------------------------------------------------------------------
package fp_pkg;

    localparam int NREG = 32;           // number of FP registers (power of two)
    localparam int AW   = 5;            // log2(NREG)
    localparam int DW   = 32;           // IEEE-754 single

    localparam logic [DW-1:0] FP_ZERO = 32'h0000_0000;

    // fp_ctl opcodes. ADD and MOV share an encoding, so these stay plain
    // constants rather than enum members.
    localparam logic [2:0] FP_CTL_ADD  = 3'd0;
    localparam logic [2:0] FP_CTL_MOV  = 3'd0;
    localparam logic [2:0] FP_CTL_SUB  = 3'd1;
    localparam logic [2:0] FP_CTL_EQ   = 3'd2;
    localparam logic [2:0] FP_CTL_LT   = 3'd3;
    localparam logic [2:0] FP_CTL_LE   = 3'd4;
    localparam logic [2:0] FP_CTL_GE   = 3'd5;
    localparam logic [2:0] FP_CTL_GT   = 3'd6;
    localparam logic [2:0] FP_CTL_MTC1 = 3'd7;

endpackage : fp_pkg

// File: rtl/fp_mfc_buf.sv
// ---------------------------------------------------------------------------
// fp_mfc_buf
// One-entry valid/ready output register for the mfc1 path (FP -> integer).
// A request is accepted when the slot is empty or is draining this cycle, so
// a continuously ready consumer sees one transfer per cycle.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_req        mfc1 request (held by the requester until o_accept)
//   i_data       value to capture on accept (already bypass-resolved)
//   i_ready      integer side consumes o_data this cycle
//   o_accept     request accepted this cycle (combinational)
//   o_valid      o_data holds a value
//   o_data       buffered value, stable while o_valid & ~i_ready
// ---------------------------------------------------------------------------
module fp_mfc_buf
    import fp_pkg::*;
#(
    parameter int W = fp_pkg::DW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_req,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_accept,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_accept = i_req & (~r_valid | i_ready);
    assign o_valid  = r_valid;
    assign o_data   = r_data;

    // NOTE: sequential state is written with <= only, so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_accept) begin
            // Covers both the empty slot and the drain-and-refill case.
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule : fp_mfc_buf

// File: rtl/fp_wb_regfile.sv
// ---------------------------------------------------------------------------
// fp_wb_regfile
// FP register file plus write-back stage. ALU results pass through a
// one-entry pending stage before reaching the array; reads are bypassed from
// the live write-back bus first, then the pending stage, then the array, so a
// result is visible to readers in the same cycle it appears on the bus.
// Also holds the FP condition flag and the mfc1 return buffer.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wb_en/wb_addr/wb_data      write-back request from the FP ALU
//   cc_en/cc_in                compare in flight / its outcome
//   rs_addr/rs_data            operand A read (combinational, bypassed)
//   rt_addr/rt_data            operand B read (combinational, bypassed)
//   cc_out                     registered condition flag
//   mfc_req/mfc_addr           mfc1 request and source register
//   mfc_accept                 request accepted this cycle
//   mfc_valid/mfc_data         buffered value to the integer side
//   mfc_ready                  integer side consumes mfc_data
// ---------------------------------------------------------------------------
module fp_wb_regfile
    import fp_pkg::*;
#(
    parameter int NREG = fp_pkg::NREG,
    parameter int AW   = fp_pkg::AW,
    parameter int DW   = fp_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          cc_en,
    input  logic          cc_in,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic          cc_out,
    input  logic          mfc_req,
    input  logic [AW-1:0] mfc_addr,
    output logic          mfc_accept,
    output logic          mfc_valid,
    output logic [DW-1:0] mfc_data,
    input  logic          mfc_ready
);

    logic [DW-1:0] r_regs [NREG];
    logic          r_pend_vld;
    logic [AW-1:0] r_pend_addr;
    logic [DW-1:0] r_pend_data;
    logic          r_cc;

    logic [DW-1:0] w_mfc_rd;

    // Bypassed read: live bus beats pending stage beats array.
    function automatic logic [DW-1:0] f_read(input logic [AW-1:0] addr);
        if (wb_en && wb_addr == addr)
            return wb_data;
        else if (r_pend_vld && r_pend_addr == addr)
            return r_pend_data;
        else
            return r_regs[addr];
    endfunction

    // NOTE: always_comb assigns every output on every path; an unassigned
    // path here would infer a latch.
    always_comb begin
        rs_data  = f_read(rs_addr);
        rt_data  = f_read(rt_addr);
        w_mfc_rd = f_read(mfc_addr);
    end

    // Commit the old pending entry and load the new one on the same edge.
    // The two never collide: the load targets the pending register, not the
    // array, so a same-address pair simply lands in order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array itself is reset because every register must
            // read zero after reset; this rules out a RAM macro here.
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else begin
            if (r_pend_vld)
                r_regs[r_pend_addr] <= r_pend_data;
            r_pend_vld <= wb_en;
            if (wb_en) begin
                r_pend_addr <= wb_addr;
                r_pend_data <= wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cc <= 1'b0;
        else if (cc_en)
            r_cc <= cc_in;
    end

    assign cc_out = r_cc;

    fp_mfc_buf #(
        .W        (DW)
    ) u_mfc_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (mfc_req),
        .i_data   (w_mfc_rd),
        .i_ready  (mfc_ready),
        .o_accept (mfc_accept),
        .o_valid  (mfc_valid),
        .o_data   (mfc_data)
    );

endmodule : fp_wb_regfile
